// File: rtl/umi_credit_pkg.sv
// Shared types and helpers for the UMI credited transmitter.
package umi_credit_pkg;

  typedef logic [31:0] stat_cnt_t;

  // Bits needed to hold a credit count in 0..credits inclusive.
  function automatic int unsigned credit_w(input int unsigned credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/umi_credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag.
module umi_credit_counter
  import umi_credit_pkg::*;
#(
  parameter int unsigned CREDITS = 8,
  localparam int unsigned CNT_W = credit_w(CREDITS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    case ({inc, dec})
      2'b10: begin
        // A return beyond the receiver depth is a protocol error: saturate and flag.
        if (count_q == FULL) overflow_d = 1'b1;
        else                 count_d    = count_q + 1'b1;
      end
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= FULL;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/umi_credit_tx.sv
// Credit-based UMI transmitter with a one-entry holding register.
// Optional statistics counters: define UMI_CREDIT_TX_STATS_EN.
module umi_credit_tx
  import umi_credit_pkg::*;
#(
  parameter int unsigned DW      = 64,
  parameter int unsigned CW      = 32,
  parameter int unsigned AW      = 64,
  parameter int unsigned CREDITS = 8,
  localparam int unsigned CNT_W  = credit_w(CREDITS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             umi_in_valid,
  input  logic [CW-1:0]    umi_in_cmd,
  input  logic [AW-1:0]    umi_in_dstaddr,
  input  logic [AW-1:0]    umi_in_srcaddr,
  input  logic [DW-1:0]    umi_in_data,
  output logic             umi_in_ready,
  output logic             umi_out_valid,
  output logic [CW-1:0]    umi_out_cmd,
  output logic [AW-1:0]    umi_out_dstaddr,
  output logic [AW-1:0]    umi_out_srcaddr,
  output logic [DW-1:0]    umi_out_data,
  input  logic             credit_return,
  output logic [CNT_W-1:0] credit_count,
  output logic             credit_overflow,
  output logic [31:0]      stat_flits,
  output logic [31:0]      stat_stalls
);

  logic          hold_valid_q, hold_valid_d;
  logic [CW-1:0] hold_cmd_q, hold_cmd_d;
  logic [AW-1:0] hold_dst_q, hold_dst_d;
  logic [AW-1:0] hold_src_q, hold_src_d;
  logic [DW-1:0] hold_data_q, hold_data_d;

  logic credit_zero;
  logic send;
  logic accept;

  assign credit_zero  = (credit_count == '0);
  assign send         = hold_valid_q && !credit_zero;
  assign umi_in_ready = !hold_valid_q || send;
  assign accept       = umi_in_valid && umi_in_ready;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_cmd_d   = hold_cmd_q;
    hold_dst_d   = hold_dst_q;
    hold_src_d   = hold_src_q;
    hold_data_d  = hold_data_q;
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_cmd_d   = umi_in_cmd;
      hold_dst_d   = umi_in_dstaddr;
      hold_src_d   = umi_in_srcaddr;
      hold_data_d  = umi_in_data;
    end else if (send) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold_valid_q <= 1'b0;
    else       hold_valid_q <= hold_valid_d;
  end

  // Payload needs no reset: it is only observed alongside hold_valid.
  always_ff @(posedge clk) begin
    hold_cmd_q  <= hold_cmd_d;
    hold_dst_q  <= hold_dst_d;
    hold_src_q  <= hold_src_d;
    hold_data_q <= hold_data_d;
  end

  assign umi_out_valid   = send;
  assign umi_out_cmd     = hold_cmd_q;
  assign umi_out_dstaddr = hold_dst_q;
  assign umi_out_srcaddr = hold_src_q;
  assign umi_out_data    = hold_data_q;

  umi_credit_counter #(
    .CREDITS (CREDITS)
  ) u_credit_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (credit_return),
    .dec      (send),
    .count    (credit_count),
    .overflow (credit_overflow)
  );

`ifdef UMI_CREDIT_TX_STATS_EN
  stat_cnt_t stat_flits_q, stat_flits_d;
  stat_cnt_t stat_stalls_q, stat_stalls_d;

  always_comb begin
    stat_flits_d  = stat_flits_q + stat_cnt_t'(send);
    stat_stalls_d = stat_stalls_q + stat_cnt_t'(hold_valid_q && credit_zero);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_flits_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_flits_q  <= stat_flits_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_flits  = stat_flits_q;
  assign stat_stalls = stat_stalls_q;
`else
  assign stat_flits  = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_umi_credit_tx.sv
// Scoreboard bench for umi_credit_tx: expected flits queued at issue, checked by a monitor.
module tb_umi_credit_tx;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 32;
  localparam int unsigned AW = 64;
  localparam int unsigned CREDITS = 8;
  localparam int unsigned CNT_W = $clog2(CREDITS + 1);

  typedef struct {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } flit_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             umi_in_valid = 1'b0;
  logic [CW-1:0]    umi_in_cmd = '0;
  logic [AW-1:0]    umi_in_dstaddr = '0;
  logic [AW-1:0]    umi_in_srcaddr = '0;
  logic [DW-1:0]    umi_in_data = '0;
  logic             umi_in_ready;
  logic             umi_out_valid;
  logic [CW-1:0]    umi_out_cmd;
  logic [AW-1:0]    umi_out_dstaddr;
  logic [AW-1:0]    umi_out_srcaddr;
  logic [DW-1:0]    umi_out_data;
  logic             credit_return = 1'b0;
  logic [CNT_W-1:0] credit_count;
  logic             credit_overflow;
  logic [31:0]      stat_flits;
  logic [31:0]      stat_stalls;

  umi_credit_tx #(
    .DW      (DW),
    .CW      (CW),
    .AW      (AW),
    .CREDITS (CREDITS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .umi_in_valid    (umi_in_valid),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_in_ready    (umi_in_ready),
    .umi_out_valid   (umi_out_valid),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .credit_return   (credit_return),
    .credit_count    (credit_count),
    .credit_overflow (credit_overflow),
    .stat_flits      (stat_flits),
    .stat_stalls     (stat_stalls)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  flit_t       exp_q[$];
  int unsigned next_id = 0;
  int unsigned total_pulses = 0;
  int unsigned run = 0;
  int unsigned last_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic flit_t mk(input int unsigned id);
    flit_t f;
    f.cmd  = 32'hC000_0000 + id;
    f.dst  = 64'hA000_0000_0000_0000 + 64'(id);
    f.src  = 64'h5000_0000_0000_0000 + 64'(id * 3);
    f.data = 64'hD000_0000_0000_0000 + 64'(id * 7);
    return f;
  endfunction

  // Monitor: every output pulse must match the oldest issued flit.
  always @(negedge clk) begin
    if (!reset) begin
      if (umi_out_valid) begin
        total_pulses++;
        run++;
        if (exp_q.size() == 0) begin
          check("unexpected_flit", 64'd1, 64'd0);
        end else begin
          flit_t e;
          e = exp_q.pop_front();
          check("out_cmd",  64'(umi_out_cmd), 64'(e.cmd));
          check("out_dst",  umi_out_dstaddr,  e.dst);
          check("out_src",  umi_out_srcaddr,  e.src);
          check("out_data", umi_out_data,     e.data);
        end
      end else begin
        if (run > 0) last_run = run;
        run = 0;
      end
    end
  end

  // Drive one flit for one cycle (called at posedge+#1); ready is expected high.
  task automatic drive(input logic cr, input logic steady);
    flit_t f;
    f = mk(next_id);
    next_id++;
    umi_in_valid   = 1'b1;
    umi_in_cmd     = f.cmd;
    umi_in_dstaddr = f.dst;
    umi_in_srcaddr = f.src;
    umi_in_data    = f.data;
    credit_return  = cr;
    exp_q.push_back(f);
    @(negedge clk);
    check("in_ready_stream", 64'(umi_in_ready), 64'd1);
    if (steady) begin
      check("steady_count", 64'(credit_count), 64'd8);
      check("steady_valid", 64'(umi_out_valid), 64'd1);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic cr);
    umi_in_valid  = 1'b0;
    credit_return = cr;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",    64'(umi_in_ready),    64'd1);
    check("rst_valid",    64'(umi_out_valid),   64'd0);
    check("rst_count",    64'(credit_count),    64'd8);
    check("rst_overflow", 64'(credit_overflow), 64'd0);
    check("rst_flits",    64'(stat_flits),      64'd0);
    check("rst_stalls",   64'(stat_stalls),     64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 9 flits, no credit returns: 8 sent back-to-back, 9th held
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b0);
    umi_in_valid = 1'b0;
    @(negedge clk);
    check("drain_count", 64'(credit_count),  64'd0);
    check("drain_ready", 64'(umi_in_ready),  64'd0);
    check("drain_valid", 64'(umi_out_valid), 64'd0);
    @(posedge clk); #1;
    check("burst_run", 64'(last_run), 64'd8);
    check("held_queue", 64'(exp_q.size()), 64'd1);

    // Single credit return from zero releases the held flit next cycle
    idle(1'b1);
    credit_return = 1'b0;
    @(negedge clk);
    check("release_valid", 64'(umi_out_valid), 64'd1);
    check("release_count", 64'(credit_count),  64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("after_release_valid", 64'(umi_out_valid), 64'd0);
    check("after_release_count", 64'(credit_count),  64'd0);
    check("after_release_ready", 64'(umi_in_ready),  64'd1);
    check("after_release_queue", 64'(exp_q.size()),  64'd0);
    @(posedge clk); #1;

    // Refill to 8, then stream 16 flits with a return every send cycle
    for (int i = 0; i < 8; i++) idle(1'b1);
    credit_return = 1'b0;
    @(negedge clk);
    check("refill_count", 64'(credit_count), 64'd8);
    @(posedge clk); #1;
    drive(1'b0, 1'b0);
    for (int i = 1; i < 16; i++) drive(1'b1, 1'b1);
    idle(1'b1);
    credit_return = 1'b0;
    @(negedge clk);
    check("stream_count",    64'(credit_count),    64'd8);
    check("stream_overflow", 64'(credit_overflow), 64'd0);
    @(posedge clk); #1;
    check("stream_run", 64'(last_run), 64'd16);

    // Return at full credit: saturate and flag until reset
    idle(1'b1);
    credit_return = 1'b0;
    @(negedge clk);
    check("ovf_count", 64'(credit_count),    64'd8);
    check("ovf_flag",  64'(credit_overflow), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check("ovf_sticky", 64'(credit_overflow), 64'd1);

    // Reset with a flit held and 3 credits left
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0);
    umi_in_valid = 1'b0;
    check("pre_rst_count", 64'(credit_count), 64'd3);
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_valid",    64'(umi_out_valid),   64'd0);
    check("mid_rst_ready",    64'(umi_in_ready),    64'd1);
    check("mid_rst_count",    64'(credit_count),    64'd8);
    check("mid_rst_overflow", 64'(credit_overflow), 64'd0);
    check("mid_rst_flits",    64'(stat_flits),      64'd0);
    check("mid_rst_stalls",   64'(stat_stalls),     64'd0);
    credit_return = 1'b1;
    @(posedge clk); #1;
    check("rst_ignores_return", 64'(credit_count), 64'd8);
    credit_return = 1'b0;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    // 8 + 1 + 16 + 5 pulses so far; the held flit must never appear
    check("total_pulses", 64'(total_pulses), 64'd30);

    // Statistics: 10 sends, 4 stalled cycles
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b0);
    umi_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    idle(1'b1);
    drive(1'b0, 1'b0);
    umi_in_valid = 1'b0;
    idle(1'b0);
    idle(1'b0);
    check("stats_count", 64'(credit_count),  64'd0);
    check("stats_queue", 64'(exp_q.size()),  64'd0);
`ifdef UMI_CREDIT_TX_STATS_EN
    check("stat_flits",  64'(stat_flits),  64'd10);
    check("stat_stalls", 64'(stat_stalls), 64'd4);
`else
    check("stat_flits",  64'(stat_flits),  64'd0);
    check("stat_stalls", 64'(stat_stalls), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
